// File: rtl/board_row_store.sv
// One board row: N_POINTS cells with guarded writes, an occupancy count, an indexed read and a clear sweep.
// Latency: a write reaches row_q and wr_ack/wr_reject after 1 cycle; a clear takes N_POINTS cycles in CLEAR.
// Backpressure: wr_ready is low while sweeping or when clr_start is high; the requester holds wr_valid.
module board_row_store #(
  parameter int N_POINTS        = 16,
  parameter int INFO_W          = 2,
  parameter int SEL_W           = 4,
  parameter int ALLOW_OVERWRITE = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [SEL_W-1:0]             wr_sel,
  input  logic [INFO_W-1:0]            wr_data,
  output logic                         wr_ack,
  output logic                         wr_reject,
  input  logic                         clr_start,
  output logic                         clr_busy,
  input  logic [SEL_W-1:0]             rd_sel,
  output logic [INFO_W-1:0]            rd_data,
  output logic [N_POINTS*INFO_W-1:0]   row_q,
  output logic [SEL_W:0]               occ_count
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [SEL_W:0]   N_EXT    = (SEL_W+1)'(N_POINTS);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_POINTS - 1);

  state_t              state;
  state_t              state_nxt;
  logic [INFO_W-1:0]   cells [N_POINTS];
  logic [SEL_W-1:0]    clr_idx;

  logic [INFO_W-1:0]   wr_cur;
  logic [INFO_W-1:0]   clr_cur;
  logic [INFO_W-1:0]   rd_cur;
  logic                wr_in_range;
  logic                wr_fire;
  logic                wr_refuse;
  logic                wr_store;
  logic                occ_inc;
  logic                occ_dec;

  // Cell lookups by explicit compare so out-of-range indices read as empty.
  always_comb begin
    wr_cur  = '0;
    clr_cur = '0;
    rd_cur  = '0;
    for (int i = 0; i < N_POINTS; i++) begin
      if (wr_sel == SEL_W'(i))  wr_cur  = cells[i];
      if (clr_idx == SEL_W'(i)) clr_cur = cells[i];
      if (rd_sel == SEL_W'(i))  rd_cur  = cells[i];
    end
  end

  // Write acceptance, refusal rules and occupancy deltas; clear and writes never overlap.
  always_comb begin
    wr_ready    = (state == ST_IDLE) && !clr_start;
    wr_fire     = wr_valid && wr_ready;
    wr_in_range = {1'b0, wr_sel} < N_EXT;
    wr_refuse   = !wr_in_range ||
                  ((ALLOW_OVERWRITE == 0) && (wr_cur != '0) && (wr_data != '0));
    wr_store    = wr_fire && !wr_refuse;
    occ_inc     = wr_store && (wr_cur == '0) && (wr_data != '0);
    occ_dec     = (wr_store && (wr_cur != '0) && (wr_data == '0)) ||
                  ((state == ST_CLEAR) && (clr_cur != '0));
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: a clear request starts the sweep, the last index ends it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clr_start) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_idx == LAST_IDX) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Cell storage, sweep index, occupancy count and the one-cycle result pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_POINTS; i++) cells[i] <= '0;
      clr_idx   <= '0;
      occ_count <= '0;
      wr_ack    <= 1'b0;
      wr_reject <= 1'b0;
    end else begin
      wr_ack    <= wr_store;
      wr_reject <= wr_fire && wr_refuse;
      if (state == ST_CLEAR) begin
        for (int i = 0; i < N_POINTS; i++) begin
          if (clr_idx == SEL_W'(i)) cells[i] <= '0;
        end
        clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + SEL_W'(1);
      end else begin
        clr_idx <= '0;
        if (wr_store) begin
          for (int i = 0; i < N_POINTS; i++) begin
            if (wr_sel == SEL_W'(i)) cells[i] <= wr_data;
          end
        end
      end
      if (occ_inc)      occ_count <= occ_count + (SEL_W+1)'(1);
      else if (occ_dec) occ_count <= occ_count - (SEL_W+1)'(1);
    end
  end

  // Flattened row view, cell i at [i*INFO_W +: INFO_W].
  always_comb begin
    row_q = '0;
    for (int i = 0; i < N_POINTS; i++) row_q[i*INFO_W +: INFO_W] = cells[i];
  end

  assign rd_data  = rd_cur;
  assign clr_busy = (state == ST_CLEAR);

endmodule
